// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronizer, glitch filter, x4 decode and a
// detent divider that drives an up/down counter's inc_en/dec_en inputs.
module quad_step_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int PULSE_DIV     = 4
) (
    input  logic clk,
    input  logic s_reset,
    input  logic enable,
    input  logic quad_a,
    input  logic quad_b,
    input  logic err_clr,
    output logic inc_en,
    output logic dec_en,
    output logic dir,
    output logic err
);

    localparam int SETTLE_LEN = SYNC_STAGES + FILTER_CYCLES;
    localparam int SW = $clog2(SETTLE_LEN + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int AW = $clog2(PULSE_DIV + 1) + 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic signed [AW-1:0] ACC_TOP = AW'(PULSE_DIV - 1);
    localparam logic signed [AW-1:0] ACC_BOT = -ACC_TOP;
    localparam logic signed [AW-1:0] ONE = 1;

    typedef enum logic {
        SETTLE,
        RUN
    } state_t;

    state_t state;
    logic [SYNC_STAGES-1:0] sync_a_q;
    logic [SYNC_STAGES-1:0] sync_b_q;
    logic sync_a;
    logic sync_b;
    logic filt_a;
    logic filt_b;
    logic [FW-1:0] cnt_a;
    logic [FW-1:0] cnt_b;
    logic [SW-1:0] settle_cnt;
    logic [1:0] prev_state;
    logic [1:0] cur;
    logic signed [AW-1:0] acc;
    logic fwd;
    logic rev;
    logic bad;

    assign sync_a = sync_a_q[SYNC_STAGES-1];
    assign sync_b = sync_b_q[SYNC_STAGES-1];
    assign cur = {filt_a, filt_b};

    always_ff @(posedge clk) begin
        if (s_reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], quad_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], quad_b};
        end
    end

    // A level is accepted only after FILTER_CYCLES consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            filt_a <= 1'b0;
            cnt_a  <= '0;
        end else if (state == SETTLE) begin
            filt_a <= sync_a;
            cnt_a  <= '0;
        end else if (sync_a == filt_a) begin
            cnt_a <= '0;
        end else if (cnt_a == FILT_LAST) begin
            filt_a <= sync_a;
            cnt_a  <= '0;
        end else begin
            cnt_a <= cnt_a + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            filt_b <= 1'b0;
            cnt_b  <= '0;
        end else if (state == SETTLE) begin
            filt_b <= sync_b;
            cnt_b  <= '0;
        end else if (sync_b == filt_b) begin
            cnt_b <= '0;
        end else if (cnt_b == FILT_LAST) begin
            filt_b <= sync_b;
            cnt_b  <= '0;
        end else begin
            cnt_b <= cnt_b + 1'b1;
        end
    end

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev_state, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            default: ;
        endcase
        bad = (prev_state ^ cur) == 2'b11;
    end

    // err set is evaluated after err_clr so a coincident illegal edge wins.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            prev_state <= 2'b00;
            acc        <= '0;
            inc_en     <= 1'b0;
            dec_en     <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
        end else begin
            inc_en     <= 1'b0;
            dec_en     <= 1'b0;
            prev_state <= cur;
            if (err_clr) err <= 1'b0;
            case (state)
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= RUN;
                    else settle_cnt <= settle_cnt + 1'b1;
                end
                RUN: begin
                    if (enable) begin
                        if (bad) begin
                            err <= 1'b1;
                            acc <= '0;
                        end else if (fwd) begin
                            if (acc == ACC_TOP) begin
                                acc    <= '0;
                                inc_en <= 1'b1;
                                dir    <= 1'b1;
                            end else begin
                                acc <= acc + ONE;
                            end
                        end else if (rev) begin
                            if (acc == ACC_BOT) begin
                                acc    <= '0;
                                dec_en <= 1'b1;
                                dir    <= 1'b0;
                            end else begin
                                acc <= acc - ONE;
                            end
                        end
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed plan plus random walk, checked by a
// pulse scoreboard fed from a position-level model (two PULSE_DIV settings).
module tb_quad_step_decoder;

    logic clk = 1'b0;
    logic s_reset;
    logic enable;
    logic quad_a;
    logic quad_b;
    logic err_clr;
    logic inc0, dec0, dir0, err0;
    logic inc1, dec1, dir1, err1;

    quad_step_decoder u_dut0 (
        .clk(clk), .s_reset(s_reset), .enable(enable),
        .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
        .inc_en(inc0), .dec_en(dec0), .dir(dir0), .err(err0)
    );

    quad_step_decoder #(.PULSE_DIV(1)) u_dut1 (
        .clk(clk), .s_reset(s_reset), .enable(enable),
        .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
        .inc_en(inc1), .dec_en(dec1), .dir(dir1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int LAT = 7;

    typedef struct {
        int at;
        bit up;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int checks = 0;
    int errors = 0;
    int acc[2];
    bit mdir[2];
    bit merr[2];
    int divs[2] = '{4, 1};
    logic [1:0] lvl;
    logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int gidx(logic [1:0] v);
        case (v)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(int k, bit up);
        ev_t e;
        e.at = cyc + LAT;
        e.up = up;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc[k] = 0;
            mdir[k] = 1'b0;
            merr[k] = 1'b0;
        end
    endtask

    // Position-level model: step distance around the 4-state Gray cycle.
    task automatic go(logic [1:0] nv);
        int d;
        d = (gidx(nv) - gidx(lvl) + 4) % 4;
        for (int k = 0; k < 2; k++) begin
            if (enable && d != 0) begin
                if (d == 2) begin
                    merr[k] = 1'b1;
                    acc[k] = 0;
                end else if (d == 1) begin
                    acc[k]++;
                    if (acc[k] == divs[k]) begin
                        acc[k] = 0;
                        mdir[k] = 1'b1;
                        push(k, 1'b1);
                    end
                end else begin
                    acc[k]--;
                    if (acc[k] == -divs[k]) begin
                        acc[k] = 0;
                        mdir[k] = 1'b0;
                        push(k, 1'b0);
                    end
                end
            end
        end
        quad_a = nv[1];
        quad_b = nv[0];
        lvl = nv;
    endtask

    task automatic hold(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_hold(logic [1:0] nv);
        go(nv);
        hold(10);
    endtask

    task automatic verify(string tag);
        check({tag, ".dir0"}, dir0, mdir[0]);
        check({tag, ".err0"}, err0, merr[0]);
        check({tag, ".dir1"}, dir1, mdir[1]);
        check({tag, ".err1"}, err1, merr[1]);
    endtask

    task automatic glitch(int len);
        quad_a = ~lvl[1];
        hold(len);
        quad_a = lvl[1];
        hold(10);
    endtask

    task automatic mon(int k, logic inc, logic dec);
        ev_t e;
        if (inc || dec) begin
            checks++;
            if (inc && dec) begin
                errors++;
                $display("FAIL excl%0d inc and dec both high at cycle %0d", k, cyc);
            end else if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                errors++;
                $display("FAIL pulse%0d unexpected inc=%0b dec=%0b at cycle %0d",
                         k, inc, dec, cyc);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (e.at != cyc || e.up != inc) begin
                    errors++;
                    $display("FAIL pulse%0d got up=%0b at %0d want up=%0b at %0d",
                             k, inc, cyc, e.up, e.at);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, inc0, dec0);
        mon(1, inc1, dec1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int act;
        s_reset = 1'b1;
        enable = 1'b0;
        err_clr = 1'b0;
        quad_a = 1'b1;
        quad_b = 1'b1;
        lvl = 2'b11;
        model_reset();
        hold(4);
        check("rst.inc", inc0, 1'b0);
        check("rst.dec", dec0, 1'b0);
        check("rst.dir", dir0, 1'b0);
        check("rst.err", err0, 1'b0);
        s_reset = 1'b0;
        hold(10);
        enable = 1'b1;
        hold(10);
        verify("settle11");

        // Re-home to 00 through reset so the directed detents start clean.
        s_reset = 1'b1;
        quad_a = 1'b0;
        quad_b = 1'b0;
        lvl = 2'b00;
        hold(3);
        model_reset();
        s_reset = 1'b0;
        hold(10);

        go_hold(2'b01); go_hold(2'b11); go_hold(2'b10); go_hold(2'b00);
        verify("fwd");
        go_hold(2'b10); go_hold(2'b11); go_hold(2'b01); go_hold(2'b00);
        verify("rev");
        for (int i = 0; i < 8; i++) go_hold(gray[(gidx(lvl) + 3) % 4]);
        verify("rev8");

        go_hold(2'b01); go_hold(2'b11); go_hold(2'b10);
        go_hold(2'b11);
        go_hold(2'b10); go_hold(2'b00);
        verify("partial");

        glitch(3);
        verify("glitch");
        go_hold(2'b11);
        verify("illegal");
        err_clr = 1'b1;
        hold(1);
        err_clr = 1'b0;
        model_reset_err: for (int k = 0; k < 2; k++) merr[k] = 1'b0;
        hold(2);
        verify("errclr");

        enable = 1'b0;
        go_hold(2'b10); go_hold(2'b00); go_hold(2'b01); go_hold(2'b11);
        enable = 1'b1;
        hold(10);
        verify("reenable");

        go_hold(2'b10); go_hold(2'b00);
        s_reset = 1'b1;
        hold(2);
        model_reset();
        check("midrst.inc", inc0, 1'b0);
        check("midrst.dir", dir0, 1'b0);
        s_reset = 1'b0;
        hold(10);
        go_hold(2'b01); go_hold(2'b11); go_hold(2'b10); go_hold(2'b00);
        verify("postrst");

        for (int i = 0; i < 150; i++) begin
            act = $urandom_range(0, 99);
            if (act < 70) begin
                go(gray[(gidx(lvl) + ($urandom_range(0, 1) ? 1 : 3)) % 4]);
                hold($urandom_range(10, 16));
            end else if (act < 78) begin
                go(~lvl);
                hold($urandom_range(10, 16));
            end else if (act < 88) begin
                glitch($urandom_range(1, 3));
            end else if (act < 94) begin
                enable = ~enable;
                hold(2);
            end else begin
                err_clr = 1'b1;
                hold(1);
                err_clr = 1'b0;
                for (int k = 0; k < 2; k++) merr[k] = 1'b0;
                hold(2);
            end
            if (i % 10 == 9) verify("rand");
        end

        hold(12);
        verify("final");
        check_int("q0.left", q0.size(), 0);
        check_int("q1.left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Decodes a 2-channel quadrature encoder (A/B) into single-cycle inc_en/dec_en step pulses.
- Output pulses feed the existing up/down counter's inc_en/dec_en inputs directly.
- Input path: synchronizer, glitch filter, x4 Gray-sequence decode, then a detent divider that emits one pulse per PULSE_DIV valid edges.
- Illegal transitions are flagged with a sticky error.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchronizer stages per channel (legal values >= 2)
FILTER_CYCLES, 4, consecutive cycles a synchronized level must differ from the filtered level before it is accepted (legal values >= 1)
PULSE_DIV, 4, valid quadrature edges per output pulse (legal values >= 1; 1 gives a pulse on every edge)

Ports:
clk  input  1  system clock; all logic on the rising edge
s_reset  input  1  synchronous, active-high reset
enable  input  1  when high, decode and pulse generation are active
quad_a  input  1  raw encoder channel A, asynchronous
quad_b  input  1  raw encoder channel B, asynchronous
err_clr  input  1  single-cycle clear of the sticky err flag
inc_en  output  1  one-cycle pulse per PULSE_DIV forward edges
dec_en  output  1  one-cycle pulse per PULSE_DIV reverse edges
dir  output  1  last valid direction: 1 = forward, 0 = reverse
err  output  1  sticky flag for an illegal (two-bit) filtered transition

Behaviour:
- Reset values: sync chains 0, filtered A/B 0, prev_state 00, filter counters 0, accumulator 0, inc_en 0, dec_en 0, dir 0, err 0, FSM in SETTLE.
- Synchronizer: each channel passes through SYNC_STAGES flip-flops; its output is sync_a/sync_b.
- Filter, per channel:
  - Counter increments on each cycle where sync differs from filt.
  - Counter clears on any cycle where sync equals filt.
  - filt takes the sync value on the edge where the counter would reach FILTER_CYCLES; the counter then clears.
  - Any pulse shorter than FILTER_CYCLES cycles is discarded.
- FSM states:
  - SETTLE: filt follows sync directly, with no filtering. prev_state follows {filt_a, filt_b}. A settle counter counts SYNC_STAGES+FILTER_CYCLES cycles, then goes to RUN. No pulses and no err in this state.
  - RUN: normal decode.
- Decode in RUN: cur = {filt_a, filt_b}, compared with prev_state each cycle; prev_state <= cur every cycle, regardless of enable.
  - Forward sequence 00->01->11->10->00 is a forward edge.
  - Reverse of that sequence is a reverse edge.
  - Both bits changing is illegal: err <= 1, accumulator <= 0, no pulse, dir unchanged.
  - No change: nothing happens.
- Detent divider, signed accumulator with range -(PULSE_DIV-1)..+(PULSE_DIV-1):
  - Forward edge: acc+1. If the result equals PULSE_DIV, then acc <= 0, inc_en pulses for 1 cycle, and dir <= 1.
  - Reverse edge: acc-1. If the result equals -PULSE_DIV, then acc <= 0, dec_en pulses for 1 cycle, and dir <= 0.
  - Partial detents cancel on reversal. Example with PULSE_DIV=4: +3 followed by one reverse edge gives +2.
- enable low: synchronizer, filter and prev_state keep tracking; no accumulator update, no pulses, no err. Re-enabling produces no spurious pulse.
- Exclusivity: inc_en and dec_en are never high in the same cycle; at most one pulse per cycle.
- Latency: first rising edge that samples a changed quad_a/quad_b to the edge asserting inc_en/dec_en is SYNC_STAGES+FILTER_CYCLES+1 edges (7 with defaults), when that edge completes a detent.
- err handling:
  - err_clr clears err on the next edge.
  - If err_clr and a new illegal transition occur in the same cycle, err stays 1 (set wins).
- s_reset mid-operation: everything returns to reset values next edge and the FSM re-enters SETTLE, so a position of 11 at reset does not raise err.

Test Plan:
- Reset with quad_a=1, quad_b=1 held; release reset, wait 10 cycles, enable=1 -> err=0, inc_en=0, dec_en=0 throughout.
- Defaults, enable=1; drive forward sequence 00->01->11->10->00, each level held 10 cycles -> exactly one inc_en pulse, 7 cycles after the 10->00 change; dir=1; dec_en never high.
- Same with reverse sequence 00->10->11->01->00 -> exactly one dec_en pulse; dir=0. With PULSE_DIV=1, 8 reverse edges -> 8 dec_en pulses.
- Forward 3 edges, reverse 1 edge, forward 2 edges -> one inc_en pulse total, after the last edge (acc 3->2->4).
- 3-cycle glitch on quad_a during RUN -> no filt change, no pulse, err=0. Then 00->11 held 10 cycles -> err=1, no pulse. Then err_clr pulse -> err=0.
- enable=0 during 4 forward edges, then enable=1 -> no pulses during or after re-enable. Assert s_reset mid-detent (acc=2) -> all outputs 0; a subsequent full detent yields exactly one inc_en.
